mul_unit: RTL and testbench

//  RV32M multiply front/back end that wraps the combinational mul32 Wallace-tree array.

---
 rtl/mul_unit.sv | 191 +++++++++++++++++++
 tb/tb_mul_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// mul_unit: RV32M MUL/MULH/MULHSU/MULHU pipeline wrapped around the unsigned mul32 array.
// Optional macro MUL_PIPE_REG_EN adds a register between mul32 and sign correction.

module mul32 #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    localparam int unsigned P_W = 2 * N;

    // Partial-product array; synthesis reduces the rows with a carry-save tree
    always_comb begin
        logic [P_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (b[i]) begin
                acc = acc + (P_W'(a) << i);
            end
        end
        p = acc;
    end
endmodule

module mul_unit #(
    parameter int unsigned N     = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);
    localparam int unsigned P_W = 2 * N;

    logic             s1_valid;
    logic [N-1:0]     s1_a;
    logic [N-1:0]     s1_b;
    logic             s1_neg;
    logic             s1_hi;
    logic [TAG_W-1:0] s1_tag;

    logic             a_neg_c;
    logic             b_neg_c;
    logic [N-1:0]     a_abs_c;
    logic [N-1:0]     b_abs_c;
    logic [P_W-1:0]   prod_c;

    logic             s2_free_c;
    logic             s1_next_free_c;
    logic             s1_adv_c;
    logic             accept_c;

    logic             cor_valid_c;
    logic [P_W-1:0]   cor_p_c;
    logic             cor_neg_c;
    logic             cor_hi_c;
    logic [TAG_W-1:0] cor_tag_c;
    logic [P_W-1:0]   res_c;
    logic [N-1:0]     word_c;

    // Operand conditioning: MULH signs both, MULHSU signs rs1 only, MULHU/MUL sign neither
    always_comb begin
        a_neg_c = ((in_op == 2'b01) || (in_op == 2'b10)) && in_a[N-1];
        b_neg_c = (in_op == 2'b01) && in_b[N-1];
        a_abs_c = a_neg_c ? (N'(0) - in_a) : in_a;
        b_abs_c = b_neg_c ? (N'(0) - in_b) : in_b;
    end

    assign s2_free_c = !out_valid || out_ready;
    assign s1_adv_c  = s1_valid && s1_next_free_c;
    assign in_ready  = !flush && (!s1_valid || s1_next_free_c);
    assign accept_c  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_neg   <= 1'b0;
            s1_hi    <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept_c) begin
                s1_valid <= 1'b1;
            end else if (s1_adv_c) begin
                s1_valid <= 1'b0;
            end
            if (accept_c) begin
                s1_a   <= a_abs_c;
                s1_b   <= b_abs_c;
                s1_neg <= a_neg_c ^ b_neg_c;
                s1_hi  <= (in_op != 2'b00);
                s1_tag <= in_tag;
            end
        end
    end

    mul32 #(.N(N)) u_mul32 (
        .a (s1_a),
        .b (s1_b),
        .p (prod_c)
    );

`ifdef MUL_PIPE_REG_EN
    logic             sp_valid;
    logic [P_W-1:0]   sp_p;
    logic             sp_neg;
    logic             sp_hi;
    logic [TAG_W-1:0] sp_tag;

    assign s1_next_free_c = !sp_valid || s2_free_c;

    // Product register between the array and sign correction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_valid <= 1'b0;
            sp_p     <= '0;
            sp_neg   <= 1'b0;
            sp_hi    <= 1'b0;
            sp_tag   <= '0;
        end else begin
            if (flush) begin
                sp_valid <= 1'b0;
            end else if (s1_next_free_c) begin
                sp_valid <= s1_valid;
            end
            if (s1_next_free_c && s1_valid) begin
                sp_p   <= prod_c;
                sp_neg <= s1_neg;
                sp_hi  <= s1_hi;
                sp_tag <= s1_tag;
            end
        end
    end

    always_comb begin
        cor_valid_c = sp_valid;
        cor_p_c     = sp_p;
        cor_neg_c   = sp_neg;
        cor_hi_c    = sp_hi;
        cor_tag_c   = sp_tag;
    end
`else
    assign s1_next_free_c = s2_free_c;

    always_comb begin
        cor_valid_c = s1_valid;
        cor_p_c     = prod_c;
        cor_neg_c   = s1_neg;
        cor_hi_c    = s1_hi;
        cor_tag_c   = s1_tag;
    end
`endif

    // Sign correction of the unsigned product and word select
    always_comb begin
        res_c  = cor_neg_c ? (P_W'(0) - cor_p_c) : cor_p_c;
        word_c = cor_hi_c ? res_c[P_W-1:N] : res_c[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_free_c) begin
                out_valid <= cor_valid_c;
            end
            if (s2_free_c && cor_valid_c) begin
                out_data <= word_c;
                out_tag  <= cor_tag_c;
            end
        end
    end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed and randomized checks of mul_unit against a 64-bit arithmetic reference.
// Honours MUL_PIPE_REG_EN for the expected latency.

module tb_mul_unit;
    localparam int unsigned N     = 32;
    localparam int unsigned TAG_W = 5;
`ifdef MUL_PIPE_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    mul_unit #(.N(N), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [N-1:0]     data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic             obs_valid = 1'b0;
    logic             obs_ready = 1'b0;
    logic             acc = 1'b0;
    logic [N-1:0]     last_data = '0;
    logic [TAG_W-1:0] last_tag = '0;
    logic             prev_stall = 1'b0;
    logic [N-1:0]     prev_data = '0;
    logic [TAG_W-1:0] prev_tag = '0;

    // Reference: extend each operand per its signedness and take the 64-bit product
    function automatic logic [N-1:0] ref_mul(input logic [1:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] prod;
        sa   = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        sb   = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        prod = sa * sb;
        return (op == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    function automatic logic [N-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: drive after negedge, sample the handshakes before the next posedge
    task automatic cycle(input logic v, input logic [1:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic rdy, input logic fl);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        #2;
        obs_valid = out_valid;
        obs_ready = in_ready;
        acc       = in_valid && in_ready;
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_tag", out_tag, prev_tag);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", out_tag, e.tag);
                last_data = out_data;
                last_tag  = out_tag;
            end
        end
        if (fl) begin
            check("flush_in_ready", in_ready, 0);
        end
        if (acc) begin
            e.data = ref_mul(op, a, b);
            e.tag  = tag;
            exp_q.push_back(e);
        end
        if (fl) begin
            exp_q.delete();
        end
        prev_stall = out_valid && !out_ready && !fl;
        prev_data  = out_data;
        prev_tag   = out_tag;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 2'b00, '0, '0, '0, rdy, 1'b0);
    endtask

    // Single request into an empty pipe; checks nominal latency and the returned word
    task automatic single(input string name, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [TAG_W-1:0] tag,
                          input logic [N-1:0] want);
        cycle(1'b1, op, a, b, tag, 1'b1, 1'b0);
        check({name, "_acc"}, acc, 1);
        for (int i = 1; i < LAT; i++) begin
            idle(1'b1);
            check({name, "_early"}, obs_valid, 0);
        end
        idle(1'b1);
        check({name, "_lat"}, obs_valid, 1);
        check({name, "_word"}, last_data, want);
        check({name, "_tagret"}, last_tag, tag);
    endtask

    initial begin
        int k;
        int n_acc;

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        single("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        single("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
        single("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
        single("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4, 32'hFFFF_FFFF);
        single("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF);
        single("mulhsu_2", 2'b10, 32'h0000_0002, 32'h8000_0000, 5'd6, 32'h0000_0001);
        single("mulh_zero", 2'b01, 32'h0000_0000, 32'h8000_0000, 5'd7, 32'h0000_0000);

        // Back-to-back MULs against a stalled consumer
        k = 1;
        for (int c = 0; c < 30; c++) begin
            cycle(k <= 4, 2'b00, 32'(k), 32'd3, 5'(k), c >= 5, 1'b0);
            if (c == LAT) begin
                check("bp_in_ready_low", obs_ready, 0);
            end
            if (acc) begin
                k++;
            end
        end
        check("bp_all_accepted", k, 5);
        check("bp_drained", exp_q.size(), 0);
        check("bp_last_data", last_data, 12);
        check("bp_last_tag", last_tag, 4);

        // Flush with two in flight and a third offered in the flush cycle
        cycle(1'b1, 2'b00, 32'd5, 32'd7, 5'd10, 1'b0, 1'b0);
        check("fl_acc1", acc, 1);
        cycle(1'b1, 2'b00, 32'd6, 32'd7, 5'd11, 1'b0, 1'b0);
        check("fl_acc2", acc, 1);
        cycle(1'b1, 2'b00, 32'd8, 32'd7, 5'd12, 1'b0, 1'b1);
        check("fl_acc3", acc, 0);
        for (int c = 0; c < 5; c++) begin
            idle(1'b1);
            check("fl_no_valid", obs_valid, 0);
        end
        single("post_flush", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13,
               ref_mul(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));

        // Traffic, then asynchronous reset in the middle of a cycle
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), 5'($urandom()),
                  $urandom_range(0, 1) == 1, 1'b0);
        end
        @(negedge clk);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        n_acc = 0;
        for (int c = 0; c < 6000 && n_acc < 1000; c++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(),
                  5'($urandom()), $urandom_range(0, 3) != 0, 1'b0);
            if (acc) begin
                n_acc++;
            end
        end
        check("rand_accepts", n_acc, 1000);
        for (int c = 0; c < 20; c++) begin
            idle(1'b1);
        end
        check("rand_drained", exp_q.size(), 0);
        check("final_idle", obs_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
